// File: rtl/chess_vga_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package     : chess_vga_pkg                                                 |
// | Description : VRAM map, tile byte layout, sprite codes and writer states.   |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
package chess_vga_pkg;

  localparam logic [9:0] VRAM_TILE_BASE   = 10'd0;
  localparam logic [9:0] VRAM_STATUS_BASE = 10'd64;
  localparam int         SB_COLS          = 17;

  localparam int GLOW_BIT   = 5;
  localparam int PARITY_BIT = 4;
  localparam int INVIS_BIT  = 7;

  typedef enum logic [3:0] {
    SPR_EMPTY    = 4'd0,
    SPR_W_PAWN   = 4'd1,
    SPR_W_KNIGHT = 4'd2,
    SPR_W_BISHOP = 4'd3,
    SPR_W_ROOK   = 4'd4,
    SPR_W_QUEEN  = 4'd5,
    SPR_W_KING   = 4'd6,
    SPR_B_PAWN   = 4'd7,
    SPR_B_KNIGHT = 4'd8,
    SPR_B_BISHOP = 4'd9,
    SPR_B_ROOK   = 4'd10,
    SPR_B_QUEEN  = 4'd11,
    SPR_B_KING   = 4'd12
  } sprite_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_T_RD  = 3'd1,
    S_T_CAP = 3'd2,
    S_T_WR  = 3'd3,
    S_E_WR  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  function automatic logic [7:0] tile_byte(input logic [3:0] code,
                                           input logic       parity,
                                           input logic       glow);
    logic [7:0] b;
    b             = {4'b0000, code};
    b[PARITY_BIT] = parity;
    b[GLOW_BIT]   = glow;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eval_bar_encoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : eval_bar_encoder                                              |
// | Description : Maps eval score and bar column to a VRAM cell byte.           |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module eval_bar_encoder
  import chess_vga_pkg::*;
#(
  parameter int         EVAL_MID = 8,
  parameter logic [6:0] BAR_CHAR = 7'h7F
) (
  input  logic signed [5:0] eval_snap,
  input  logic        [4:0] col,
  output logic        [7:0] cell_byte
);

  logic signed [6:0] w_sum;
  logic        [4:0] w_wcells;

  // 7-bit signed sum cannot overflow: range is -24..39
  always_comb begin
    w_sum    = $signed({eval_snap[5], eval_snap}) + $signed(7'(EVAL_MID));
    w_wcells = 5'd0;
    if (w_sum[6]) begin
      w_wcells = 5'd0;
    end else if (w_sum > $signed(7'(SB_COLS))) begin
      w_wcells = 5'(SB_COLS);
    end else begin
      w_wcells = w_sum[4:0];
    end
    cell_byte            = {1'b0, BAR_CHAR};
    cell_byte[INVIS_BIT] = (col >= w_wcells);
  end

endmodule
`default_nettype wire

// File: rtl/vram_board_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : vram_board_writer                                             |
// | Description : Avalon-MM master writing board tiles and eval bar to VRAM.    |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module vram_board_writer
  import chess_vga_pkg::*;
#(
  parameter int         EVAL_ROW = 20,
  parameter int         EVAL_MID = 8,
  parameter logic [6:0] BAR_CHAR = 7'h7F
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              refresh,
  input  logic              eval_update,
  input  logic signed [5:0] eval_score,
  input  logic       [63:0] move_mask,
  output logic        [5:0] board_addr,
  input  logic        [3:0] board_data,
  output logic              busy,
  output logic              pass_done,
  output logic        [9:0] AVL_ADDR,
  output logic        [7:0] AVL_WRITEDATA,
  output logic              AVL_WRITE,
  output logic              AVL_CS,
  output logic              AVL_BYTE_EN,
  input  logic              AVL_WAITREQUEST
);

  localparam logic [9:0] c_eval_base = 10'(int'(VRAM_STATUS_BASE) + EVAL_ROW * SB_COLS);
  localparam logic [4:0] c_last_col  = 5'(SB_COLS - 1);

  state_e            r_state, w_next;
  logic        [5:0] r_idx;
  logic        [4:0] r_col;
  logic              r_ref_pend, r_ev_pend;
  logic       [63:0] r_mask_snap;
  logic signed [5:0] r_eval_snap;
  logic        [7:0] r_tile;
  logic        [7:0] w_cell_byte;
  logic              w_ref_req, w_ev_req;
  logic              w_start_board, w_start_eval;

  // A pulse in the same cycle as a pass start is consumed by that start
  assign w_ref_req = r_ref_pend | refresh;
  assign w_ev_req  = r_ev_pend  | eval_update;

  eval_bar_encoder #(
    .EVAL_MID (EVAL_MID),
    .BAR_CHAR (BAR_CHAR)
  ) u_eval_bar_encoder (
    .eval_snap (r_eval_snap),
    .col       (r_col),
    .cell_byte (w_cell_byte)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_idx       <= 6'd0;
      r_col       <= 5'd0;
      r_ref_pend  <= 1'b0;
      r_ev_pend   <= 1'b0;
      r_mask_snap <= 64'd0;
      r_eval_snap <= 6'sd0;
      r_tile      <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_ref_pend <= w_start_board ? 1'b0 : w_ref_req;
      r_ev_pend  <= w_start_eval  ? 1'b0 : w_ev_req;
      if (w_start_board) begin
        r_idx       <= 6'd0;
        r_mask_snap <= move_mask;
      end else if (r_state == S_T_WR && !AVL_WAITREQUEST) begin
        r_idx <= r_idx + 6'd1;
      end
      if (w_start_eval) begin
        r_col       <= 5'd0;
        r_eval_snap <= eval_score;
      end else if (r_state == S_E_WR && !AVL_WAITREQUEST) begin
        r_col <= r_col + 5'd1;
      end
      if (r_state == S_T_CAP) begin
        r_tile <= tile_byte(board_data, r_idx[3] ^ r_idx[0], r_mask_snap[r_idx]);
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_start_board = 1'b0;
    w_start_eval  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ref_req) begin
          w_next        = S_T_RD;
          w_start_board = 1'b1;
        end else if (w_ev_req) begin
          w_next       = S_E_WR;
          w_start_eval = 1'b1;
        end
      end
      S_T_RD:  w_next = S_T_CAP;
      S_T_CAP: w_next = S_T_WR;
      S_T_WR: begin
        if (!AVL_WAITREQUEST) begin
          if (r_idx == 6'd63) begin
            if (w_ev_req) begin
              w_next       = S_E_WR;
              w_start_eval = 1'b1;
            end else begin
              w_next = S_DONE;
            end
          end else begin
            w_next = S_T_RD;
          end
        end
      end
      S_E_WR: begin
        if (!AVL_WAITREQUEST && r_col == c_last_col) begin
          if (w_ref_req) begin
            w_next        = S_T_RD;
            w_start_board = 1'b1;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    board_addr    = r_idx;
    busy          = (r_state != S_IDLE);
    pass_done     = (r_state == S_DONE);
    AVL_WRITE     = 1'b0;
    AVL_ADDR      = 10'd0;
    AVL_WRITEDATA = 8'd0;
    if (r_state == S_T_WR) begin
      AVL_WRITE     = 1'b1;
      AVL_ADDR      = VRAM_TILE_BASE + {4'd0, r_idx};
      AVL_WRITEDATA = r_tile;
    end else if (r_state == S_E_WR) begin
      AVL_WRITE     = 1'b1;
      AVL_ADDR      = c_eval_base + {5'd0, r_col};
      AVL_WRITEDATA = w_cell_byte;
    end
    AVL_CS      = AVL_WRITE;
    AVL_BYTE_EN = AVL_WRITE;
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_board_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_vram_board_writer                                          |
// | Description : Randomised self-checking bench for vram_board_writer.         |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_vram_board_writer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              refresh, eval_update;
  logic signed [5:0] eval_score;
  logic       [63:0] move_mask;
  logic        [5:0] board_addr;
  logic        [3:0] board_data;
  logic              busy, pass_done;
  logic        [9:0] avl_addr;
  logic        [7:0] avl_writedata;
  logic              avl_write, avl_cs, avl_byte_en, avl_waitrequest;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        wr_q[$];
  int         done_q[$];
  logic [3:0] mem [64];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         t_start;
  logic       prev_stall;
  logic [9:0] prev_addr;
  logic [7:0] prev_data;

  vram_board_writer u_dut (
    .CLK             (clk),
    .RESET           (rst_n),
    .refresh         (refresh),
    .eval_update     (eval_update),
    .eval_score      (eval_score),
    .move_mask       (move_mask),
    .board_addr      (board_addr),
    .board_data      (board_data),
    .busy            (busy),
    .pass_done       (pass_done),
    .AVL_ADDR        (avl_addr),
    .AVL_WRITEDATA   (avl_writedata),
    .AVL_WRITE       (avl_write),
    .AVL_CS          (avl_cs),
    .AVL_BYTE_EN     (avl_byte_en),
    .AVL_WAITREQUEST (avl_waitrequest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) board_data <= mem[board_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: square i -> {glow, checkerboard parity, sprite code}
  function automatic logic [7:0] exp_tile(input int i, input logic [3:0] code, input logic glow);
    int row, col;
    row = i / 8;
    col = i % 8;
    return {2'b00, glow, 1'((row + col) % 2), code};
  endfunction

  // Reference: white cells = 8 + score clamped to 0..17; others black
  function automatic logic [7:0] exp_cell(input int col, input int score);
    int w;
    w = 8 + score;
    if (w < 0)  w = 0;
    if (w > 17) w = 17;
    return (col >= w) ? 8'hFF : 8'h7F;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("cs_be", {avl_cs, avl_byte_en}, {avl_write, avl_write});
      if (prev_stall) begin
        chk("stall_addr", avl_addr, prev_addr);
        chk("stall_data", avl_writedata, prev_data);
      end
      if (avl_write && !avl_waitrequest) wr_q.push_back('{avl_addr, avl_writedata, cyc});
      if (pass_done) done_q.push_back(cyc);
      prev_stall = avl_write && avl_waitrequest;
      prev_addr  = avl_addr;
      prev_data  = avl_writedata;
    end
  end

  // mode 0: no stalls, 1: random stalls, 2: 5-cycle stall on square 10,
  // 3: refresh pulse and move_mask flip while square 30 is written
  task automatic run(input bit rf, input bit ev, input int n_done, input int mode);
    int  k;
    int  stall_left;
    bit  injected;
    k          = 0;
    stall_left = 5;
    injected   = 1'b0;
    wr_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    t_start     = cyc;
    refresh     = rf;
    eval_update = ev;
    while (done_q.size() < n_done && k < 3000) begin
      @(posedge clk); #1;
      k++;
      refresh         = 1'b0;
      eval_update     = 1'b0;
      avl_waitrequest = 1'b0;
      case (mode)
        1: avl_waitrequest = ($urandom_range(0, 2) == 0);
        2: if (avl_write && avl_addr == 10'd10 && stall_left > 0) begin
             avl_waitrequest = 1'b1;
             stall_left--;
           end
        3: if (!injected && avl_write && avl_addr == 10'd30) begin
             refresh   = 1'b1;
             move_mask = ~move_mask;
             injected  = 1'b1;
           end
        default: ;
      endcase
    end
    avl_waitrequest = 1'b0;
    chk("pass_timeout", 64'(done_q.size() >= n_done), 64'd1);
  endtask

  task automatic check_board(input int base, input logic [63:0] mask);
    for (int i = 0; i < 64; i++) begin
      if (base + i < wr_q.size()) begin
        chk($sformatf("bd_addr[%0d]", i), wr_q[base+i].addr, 64'(i));
        chk($sformatf("bd_data[%0d]", i), wr_q[base+i].data, exp_tile(i, mem[i], mask[i]));
      end
    end
  endtask

  task automatic check_eval(input int base, input int score);
    for (int c = 0; c < 17; c++) begin
      if (base + c < wr_q.size()) begin
        chk($sformatf("ev_addr[%0d]", c), wr_q[base+c].addr, 64'(404 + c));
        chk($sformatf("ev_data[%0d] s=%0d", c, score), wr_q[base+c].data, exp_cell(c, score));
      end
    end
  endtask

  initial begin
    logic [63:0] m0;
    int          s;
    rst_n = 1'b0; refresh = 1'b0; eval_update = 1'b0;
    eval_score = 6'sd0; move_mask = 64'd0; avl_waitrequest = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 4'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {busy, pass_done, avl_write, avl_cs, avl_byte_en, avl_addr, avl_writedata, board_addr}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Known board: code = idx[3:0], only square 0 glows
    move_mask = 64'h1;
    run(1'b1, 1'b0, 1, 0);
    chk("t1_nwr", wr_q.size(), 64);
    check_board(0, 64'h1);
    if (wr_q.size() >= 10) begin
      chk("t1_a0", wr_q[0].data, 8'h20);
      chk("t1_a1", wr_q[1].data, 8'h11);
      chk("t1_a9", wr_q[9].data, 8'h09);
      chk("t1_first_lat", wr_q[0].cyc - t_start, 3);
    end
    if (done_q.size() >= 1) chk("t1_done_cyc", done_q[0] - t_start, 193);
    chk("t1_busy_low", busy, 1'b0);

    // Eval bar: boundary scores, then random with random stalls
    eval_score = 6'sd0;
    run(1'b0, 1'b1, 1, 0);
    chk("t2_nwr", wr_q.size(), 17);
    check_eval(0, 0);
    if (done_q.size() >= 1) chk("t2_done_cyc", done_q[0] - t_start, 18);
    eval_score = -6'sd32;
    run(1'b0, 1'b1, 1, 0);
    check_eval(0, -32);
    eval_score = 6'sd20;
    run(1'b0, 1'b1, 1, 0);
    check_eval(0, 20);
    eval_score = 6'sd31;
    run(1'b0, 1'b1, 1, 0);
    check_eval(0, 31);
    for (int t = 0; t < 6; t++) begin
      eval_score = 6'($urandom_range(0, 63));
      s = int'(eval_score);
      run(1'b0, 1'b1, 1, 1);
      chk("t2r_nwr", wr_q.size(), 17);
      check_eval(0, s);
    end

    // Random board, random mask, random stalls
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 64; i++) mem[i] = 4'($urandom_range(0, 12));
      move_mask = {$urandom, $urandom};
      m0 = move_mask;
      run(1'b1, 1'b0, 1, 1);
      chk("t1r_nwr", wr_q.size(), 64);
      check_board(0, m0);
    end

    // Held waitrequest on square 10
    m0 = move_mask;
    run(1'b1, 1'b0, 1, 2);
    chk("t3_nwr", wr_q.size(), 64);
    check_board(0, m0);
    if (wr_q.size() >= 12) chk("t3_sq11_next", wr_q[11].cyc - wr_q[10].cyc, 3);
    if (done_q.size() >= 1) chk("t3_done_cyc", done_q[0] - t_start, 198);

    // Refresh at square 30 re-arms; mid-pass mask flip only affects pass 2
    m0 = move_mask;
    run(1'b1, 1'b0, 2, 3);
    chk("t4_nwr", wr_q.size(), 128);
    chk("t4_ndone", done_q.size(), 2);
    check_board(0, m0);
    check_board(64, ~m0);
    if (done_q.size() >= 2) chk("t4_gap", done_q[1] - done_q[0], 194);

    // Simultaneous refresh + eval_update
    eval_score = -6'sd5;
    m0 = move_mask;
    run(1'b1, 1'b1, 1, 0);
    chk("t5_nwr", wr_q.size(), 81);
    check_board(0, m0);
    check_eval(64, -5);
    if (wr_q.size() >= 65) chk("t5_no_gap", wr_q[64].cyc - wr_q[63].cyc, 1);
    if (done_q.size() >= 1) chk("t5_done_cyc", done_q[0] - t_start, 210);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_one_done", done_q.size(), 1);

    // Asynchronous reset while square 40 is being written
    @(posedge clk); #1;
    refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
    for (int k = 0; k < 400 && !(avl_write && avl_addr == 10'd40); k++) begin
      @(posedge clk); #1;
    end
    chk("t6_reach", {avl_write, avl_addr}, {1'b1, 10'd40});
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_outs", {busy, pass_done, avl_write, avl_cs, avl_byte_en, avl_addr, avl_writedata, board_addr}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wr_q.delete();
    done_q.delete();
    repeat (30) @(posedge clk);
    #1;
    chk("t6_no_writes", wr_q.size(), 0);
    chk("t6_no_done", done_q.size(), 0);
    chk("t6_idle", busy, 1'b0);
    eval_score = 6'sd3;
    run(1'b0, 1'b1, 1, 0);
    chk("t6_after_nwr", wr_q.size(), 17);
    check_eval(0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
